// File: rtl/transfer_responder_if.sv
// Transfer responder bus interface.
// Carries the control-word handshake, the memory request/acknowledge
// channel and the load/store completion strobes between a requester
// (master) and the transfer responder (slave).
//   controlWord/cwValid/cwReady/address/storeData : control word handshake
//   memRequest/memWrite/memAddress/memWriteData    : memory request side
//   memReadData/memAck                             : memory response side
//   loadData/loadValid/destReg/storeDone/error/busy: completion status
interface transfer_responder_if #(
  parameter int ADDR_W = 64
);
  logic [28:0]       controlWord;
  logic              cwValid;
  logic              cwReady;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] storeData;
  logic              memRequest;
  logic              memWrite;
  logic [ADDR_W-1:0] memAddress;
  logic [ADDR_W-1:0] memWriteData;
  logic [ADDR_W-1:0] memReadData;
  logic              memAck;
  logic [ADDR_W-1:0] loadData;
  logic              loadValid;
  logic [4:0]        destReg;
  logic              storeDone;
  logic              error;
  logic              busy;

  modport slave (
    input  controlWord, cwValid, address, storeData, memReadData, memAck,
    output cwReady, memRequest, memWrite, memAddress, memWriteData,
           loadData, loadValid, destReg, storeDone, error, busy
  );

  modport master (
    output controlWord, cwValid, address, storeData, memReadData, memAck,
    input  cwReady, memRequest, memWrite, memAddress, memWriteData,
           loadData, loadValid, destReg, storeDone, error, busy
  );
endinterface

// File: rtl/transfer_responder.sv
// Transfer responder.
// Accepts a decoded control word with its effective address and store
// data, classifies it as LOAD, STORE or NOP, and runs the memory access:
// one request phase (ACCESS) bounded by a wait counter, followed by a
// single-cycle completion (RESP) or error (FAULT) strobe.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : transfer_responder_if slave modport (handshake, memory, status)
// All outputs are driven from registers.
module transfer_responder #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  transfer_responder_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    FAULT  = 2'd3
  } state_t;

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_t            state_r;
  logic [3:0]        wait_cnt_r;
  logic              is_store_r;
  logic [4:0]        dest_reg_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] store_data_r;
  logic [ADDR_W-1:0] load_data_r;
  logic              cw_ready_r;
  logic              busy_r;
  logic              mem_request_r;
  logic              mem_write_r;
  logic              load_valid_r;
  logic              store_done_r;
  logic              error_r;

  logic              ramw_s;
  logic              is_load_s;
  logic              is_xfer_s;
  logic              aligned_s;
  logic [3:0]        wait_cnt_next_s;

  // Decode of the incoming control word; only meaningful in IDLE.
  assign ramw_s          = bus.controlWord[5];
  assign is_load_s       = !ramw_s && (bus.controlWord[4:3] == 2'b01) && bus.controlWord[6];
  assign is_xfer_s       = ramw_s || is_load_s;
  assign aligned_s       = (bus.address[2:0] == 3'b000);
  assign wait_cnt_next_s = wait_cnt_r + 4'd1;

  // Transfer FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      wait_cnt_r    <= 4'd0;
      is_store_r    <= 1'b0;
      dest_reg_r    <= 5'd0;
      addr_r        <= '0;
      store_data_r  <= '0;
      load_data_r   <= '0;
      cw_ready_r    <= 1'b1;
      busy_r        <= 1'b0;
      mem_request_r <= 1'b0;
      mem_write_r   <= 1'b0;
      load_valid_r  <= 1'b0;
      store_done_r  <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      load_valid_r <= 1'b0;
      store_done_r <= 1'b0;
      error_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cwValid) begin
            // Every acceptance latches the word, including a NOP.
            is_store_r   <= ramw_s;
            dest_reg_r   <= bus.controlWord[26:22];
            addr_r       <= bus.address;
            store_data_r <= bus.storeData;
            if (is_xfer_s && aligned_s) begin
              state_r       <= ACCESS;
              wait_cnt_r    <= 4'd0;
              mem_request_r <= 1'b1;
              mem_write_r   <= ramw_s;
              cw_ready_r    <= 1'b0;
              busy_r        <= 1'b1;
            end else if (is_xfer_s) begin
              // Misaligned: report immediately, never touch memory.
              state_r    <= FAULT;
              error_r    <= 1'b1;
              cw_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          // Acknowledge wins over a timeout reached in the same cycle.
          if (bus.memAck) begin
            state_r       <= RESP;
            mem_request_r <= 1'b0;
            mem_write_r   <= 1'b0;
            if (is_store_r) begin
              store_done_r <= 1'b1;
            end else begin
              load_valid_r <= 1'b1;
              load_data_r  <= bus.memReadData;
            end
          end else if (wait_cnt_next_s == TIMEOUT_C) begin
            state_r       <= FAULT;
            wait_cnt_r    <= wait_cnt_next_s;
            mem_request_r <= 1'b0;
            mem_write_r   <= 1'b0;
            error_r       <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_next_s;
          end
        end
        RESP, FAULT: begin
          state_r    <= IDLE;
          cw_ready_r <= 1'b1;
          busy_r     <= 1'b0;
        end
        default: begin
          state_r       <= IDLE;
          wait_cnt_r    <= 4'd0;
          cw_ready_r    <= 1'b1;
          busy_r        <= 1'b0;
          mem_request_r <= 1'b0;
          mem_write_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cwReady      = cw_ready_r;
  assign bus.busy         = busy_r;
  assign bus.memRequest   = mem_request_r;
  assign bus.memWrite     = mem_write_r;
  assign bus.memAddress   = addr_r;
  assign bus.memWriteData = store_data_r;
  assign bus.loadData     = load_data_r;
  assign bus.loadValid    = load_valid_r;
  assign bus.destReg      = dest_reg_r;
  assign bus.storeDone    = store_done_r;
  assign bus.error        = error_r;

endmodule

// File: tb/tb_transfer_responder.sv
// Self-checking bench for transfer_responder: directed scenarios plus
// randomized transfers, each checked cycle by cycle against a
// per-transfer timeline predicted from the classification, alignment
// and acknowledge delay of that transfer.
module tb_transfer_responder;

  localparam int TIMEOUT = 15;
  localparam int ADDR_W  = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Model state carried across transfers.
  logic [63:0] exp_ld   = 64'd0;
  logic [4:0]  exp_dest = 5'd0;

  transfer_responder_if #(.ADDR_W(ADDR_W)) bus ();

  transfer_responder #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = NOP, 1 = LOAD, 2 = STORE
  function automatic int classify(input logic [28:0] cw);
    if (cw[5]) return 2;
    if (cw[4:3] == 2'b01 && cw[6]) return 1;
    return 0;
  endfunction

  function automatic logic [28:0] mk_cw(input logic regw, input logic ramw,
                                        input logic [1:0] dsel, input logic [4:0] da);
    logic [28:0] cw;
    cw        = 29'($urandom);
    cw[26:22] = da;
    cw[6]     = regw;
    cw[5]     = ramw;
    cw[4:3]   = dsel;
    return cw;
  endfunction

  task automatic check_quiet(input string tag, input logic ready);
    check_val({tag, "_req"},   bus.memRequest, 1'b0);
    check_val({tag, "_lv"},    bus.loadValid,  1'b0);
    check_val({tag, "_sd"},    bus.storeDone,  1'b0);
    check_val({tag, "_err"},   bus.error,      1'b0);
    check_val({tag, "_ready"}, bus.cwReady,    ready);
    check_val({tag, "_busy"},  bus.busy,       !ready);
  endtask

  task automatic scramble_inputs();
    bus.controlWord = 29'($urandom);
    bus.address     = {$urandom, $urandom};
    bus.storeData   = {$urandom, $urandom};
  endtask

  // Runs one transfer starting just after a negedge with the DUT idle.
  // ack_at: ACCESS cycle (1-based) carrying memAck; 0 or >TIMEOUT = never.
  task automatic run_txn(input logic [28:0] cw, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input int ack_at, input bit hold);
    int kind;
    bit aligned;
    bit acked;
    int n_req;
    kind    = classify(cw);
    aligned = (addr[2:0] == 3'b000);
    acked   = (kind != 0) && aligned && (ack_at >= 1) && (ack_at <= TIMEOUT);
    n_req   = (kind == 0 || !aligned) ? 0 : (acked ? ack_at : TIMEOUT);

    check_val("ready_before", bus.cwReady, 1'b1);
    bus.cwValid     = 1'b1;
    bus.controlWord = cw;
    bus.address     = addr;
    bus.storeData   = sdata;
    bus.memAck      = 1'($urandom);
    bus.memReadData = {$urandom, $urandom};
    exp_dest        = cw[26:22];
    @(negedge clock);
    bus.cwValid = hold && (kind != 0);
    bus.memAck  = 1'b0;
    scramble_inputs();

    if (kind == 0) begin
      check_quiet("nop", 1'b1);
      check_val("nop_dest", bus.destReg, exp_dest);
      check_val("nop_ld", bus.loadData, exp_ld);
      return;
    end

    for (int k = 1; k <= n_req; k++) begin
      check_val("acc_req",   bus.memRequest,   1'b1);
      check_val("acc_wr",    bus.memWrite,     kind == 2);
      check_val("acc_addr",  bus.memAddress,   addr);
      check_val("acc_wdata", bus.memWriteData, sdata);
      check_val("acc_lv",    bus.loadValid,    1'b0);
      check_val("acc_sd",    bus.storeDone,    1'b0);
      check_val("acc_err",   bus.error,        1'b0);
      check_val("acc_ready", bus.cwReady,      1'b0);
      check_val("acc_busy",  bus.busy,         1'b1);
      bus.memAck      = (k == ack_at);
      bus.memReadData = (k == ack_at) ? rdata : {$urandom, $urandom};
      scramble_inputs();
      @(negedge clock);
    end

    if (acked && kind == 1) exp_ld = rdata;
    check_val("stb_req",   bus.memRequest, 1'b0);
    check_val("stb_err",   bus.error,      !acked);
    check_val("stb_lv",    bus.loadValid,  acked && kind == 1);
    check_val("stb_sd",    bus.storeDone,  acked && kind == 2);
    check_val("stb_ready", bus.cwReady,    1'b0);
    check_val("stb_busy",  bus.busy,       1'b1);
    check_val("stb_dest",  bus.destReg,    exp_dest);
    check_val("stb_ld",    bus.loadData,   exp_ld);
    // memAck outside ACCESS must be ignored.
    bus.memAck      = 1'($urandom);
    bus.memReadData = {$urandom, $urandom};
    @(negedge clock);

    bus.cwValid = 1'b0;
    bus.memAck  = 1'b0;
    check_quiet("done", 1'b1);
    check_val("done_dest", bus.destReg,  exp_dest);
    check_val("done_ld",   bus.loadData, exp_ld);
  endtask

  initial begin
    bus.cwValid     = 1'b0;
    bus.controlWord = 29'd0;
    bus.address     = 64'd0;
    bus.storeData   = 64'd0;
    bus.memReadData = 64'd0;
    bus.memAck      = 1'b0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_quiet("rst", 1'b1);
    check_val("rst_wr",   bus.memWrite,   1'b0);
    check_val("rst_addr", bus.memAddress, 64'd0);
    check_val("rst_ld",   bus.loadData,   64'd0);
    check_val("rst_dest", bus.destReg,    5'd0);
    reset = 1'b0;

    // Directed: store acked on 2nd ACCESS cycle
    run_txn(mk_cw(1'b0, 1'b1, 2'b00, 5'd3), 64'h40, 64'hDEADBEEF, 64'd0, 2, 1'b0);
    // Directed: load DA=7 acked at once
    run_txn(mk_cw(1'b1, 1'b0, 2'b01, 5'd7), 64'h80, 64'd0, 64'h1234, 1, 1'b0);
    check_val("load_dest7", bus.destReg, 5'd7);
    check_val("load_data",  bus.loadData, 64'h1234);
    // Directed: misaligned load
    run_txn(mk_cw(1'b1, 1'b0, 2'b01, 5'd9), 64'h43, 64'd0, 64'h5555, 1, 1'b0);
    check_val("mis_ld_kept", bus.loadData, 64'h1234);
    // Directed: store timeout, then ack exactly on the last cycle
    run_txn(mk_cw(1'b0, 1'b1, 2'b10, 5'd1), 64'h100, 64'hCAFE, 64'd0, 0, 1'b0);
    run_txn(mk_cw(1'b0, 1'b1, 2'b10, 5'd2), 64'h108, 64'hBEEF, 64'd0, TIMEOUT, 1'b0);
    // Directed: NOP, then back-pressure with cwValid held while busy
    run_txn(mk_cw(1'b1, 1'b0, 2'b00, 5'd4), 64'h200, 64'h1, 64'd0, 1, 1'b0);
    run_txn(mk_cw(1'b1, 1'b0, 2'b01, 5'd5), 64'h208, 64'h2, 64'hABCD, 3, 1'b1);

    // Directed: asynchronous reset in the middle of ACCESS
    bus.cwValid     = 1'b1;
    bus.controlWord = mk_cw(1'b0, 1'b1, 2'b00, 5'd6);
    bus.address     = 64'h300;
    bus.storeData   = 64'h77;
    bus.memAck      = 1'b0;
    @(negedge clock);
    bus.cwValid = 1'b0;
    @(negedge clock);
    check_val("mid_req", bus.memRequest, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("async_rst", 1'b1);
    check_val("async_rst_addr", bus.memAddress, 64'd0);
    check_val("async_rst_ld",   bus.loadData,   64'd0);
    exp_ld   = 64'd0;
    exp_dest = 5'd0;
    @(negedge clock);
    check_quiet("rst_hold", 1'b1);
    reset = 1'b0;
    // First acceptance on the very first edge after release.
    run_txn(mk_cw(1'b1, 1'b0, 2'b01, 5'd11), 64'h400, 64'd0, 64'h9999, 2, 1'b0);

    // Randomized transfers
    for (int i = 0; i < 40; i++) begin
      logic [28:0] cw;
      logic [63:0] addr;
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       cw = mk_cw(1'($urandom), 1'b1, 2'($urandom), 5'($urandom));
        1, 2:    cw = mk_cw(1'b1, 1'b0, 2'b01, 5'($urandom));
        default: cw = mk_cw(1'($urandom), 1'b0, 2'($urandom), 5'($urandom));
      endcase
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) addr[2:0] = 3'b000;
      run_txn(cw, addr, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, TIMEOUT + 2)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
